instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction-fetch stage of the OTTER pipeline: owns the program counter, issues instruction-memory reads over a req/ack handshake, and presents one fetched instruction and its PC per cycle to the IF/ID pipeline register. It sits directly upstream of the IF/ID register. It honours stall from the hazard logic and redirect from branch/jump resolution. Invalid or flushed slots present NOP (0x00000013), so the IF/ID register never latches garbage.

## Interface
- RESET_PC, 32'h00000000, PC value after reset.
- CLK  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high; clock CLK.
- stall  in  1  IF/ID not accepting this cycle (its enable is low).
- redirect  in  1  branch/jump taken; flush and restart at redirect_pc.
- redirect_pc  in  32  new fetch address; valid when redirect=1.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  read address; stable while imem_req=1 and no imem_ack.
- imem_ack  in  1  read complete; imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  output buffer holds a real instruction.
- if_instr  out  32  instruction to IF/ID; 0x00000013 when if_valid=0.
- if_pc  out  32  PC of if_instr.

## Operation
- Registers:
  - pc (next fetch address);
  - output buffer {if_valid, if_instr, if_pc};
  - pending (request outstanding from an earlier cycle);
  - drop_addr;
  - state ∈ {RUN, DROP}.
- Consume = if_valid && !stall at a rising edge. The downstream stage takes the buffer only then.
- imem_req:
  - RUN: pending || !if_valid || !stall. A new request is issued only when the buffer is empty or being consumed.
  - DROP: 1.
  - Forced 0 during any cycle with rst=1.
- imem_addr: pc in RUN; drop_addr in DROP.
- Outstanding = imem_req && !imem_ack. pending <= outstanding.
- Invariant: the buffer is empty or being consumed whenever imem_ack arrives. A stalled, full buffer never meets an ack.
- Edge update priority: rst > redirect > ack/consume.
- Redirect, any state:
  - pc <= redirect_pc; if_valid <= 0; if_instr <= 0x00000013.
  - Ack in the same cycle: rdata discarded; state <= RUN.
  - Request outstanding (no ack): drop_addr <= current imem_addr; state <= DROP.
  - Otherwise: state <= RUN.
- RUN with ack, no redirect: if_instr <= imem_rdata; if_pc <= pc; if_valid <= 1; pc <= pc + 4.
- RUN, consume with no ack: if_valid <= 0; if_instr <= 0x00000013.
- RUN, stall with valid buffer: buffer holds unchanged.
- DROP: request held at drop_addr until ack. That rdata is discarded, buffer untouched, state <= RUN. The next request at pc issues from the following cycle.
- Redirect while in DROP: pc updated; stay DROP; drop_addr unchanged.
- PC arithmetic is modulo 2^32: 0xFFFFFFFC + 4 = 0x00000000. pc[1:0] is not checked.
- rst mid-request abandons the request. Instruction memory must be reset together with this block.

## Timing
- Reset values:
  - pc = RESET_PC; state = RUN; pending = 0; drop_addr = 0;
  - if_valid = 0; if_instr = 0x00000013; if_pc = 0; imem_req = 0.
- First imem_req=1 (addr RESET_PC) in the first cycle with rst=0.
- Latency: ack at edge N gives if_valid=1 after edge N.
- With a zero-wait memory (ack same cycle as req) and no stall: one instruction per cycle, no bubbles.
- Redirect at edge N:
  - if_valid=0 after N.
  - Outside DROP: request at redirect_pc in cycle N+1.
  - In DROP: request at redirect_pc in the cycle after the dropped ack.
- Stall adds no latency beyond the stalled cycles. If a request is pending when stall asserts, it completes into the empty buffer.

## Test plan
- Reset release, RESET_PC=0x100, zero-wait memory returning addr^0xA5A50000, no stall:
  - imem_addr 0x100, 0x104, 0x108 on consecutive cycles.
  - if_pc follows one cycle later, if_valid=1 continuously.
  - if_instr=0x00000013 and if_valid=0 during reset.
- Stall for 3 cycles with buffer valid at if_pc=0x108:
  - Buffer frozen; imem_req=0 after any pending request completes.
  - On release, 0x10C is fetched next; no instruction lost or duplicated.
- 3-wait-state memory, redirect to 0x200 in the 2nd wait cycle of a fetch at 0x110:
  - imem_addr holds 0x110 until ack; that word is never presented.
  - Next request is 0x200; if_valid=0 until 0x200 returns.
- Redirect to 0x300 in the same cycle as an ack: rdata discarded, if_instr=0x00000013, next imem_addr=0x300.
- Redirect to 0xFFFFFFF8 with zero-wait memory: PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- rst asserted while a request is outstanding and stall=1: the next edge restores all reset values and imem_req drops to 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the program counter, fetches over a req/ack
// handshake and hands one instruction per cycle (NOP when empty) to IF/ID.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        RUN,
        DROP
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] drop_addr;
    logic        pending;
    logic        outstanding;

    // A fresh request only goes out when the buffer is empty or leaving this
    // cycle; an already-issued request is held until memory answers.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        imem_req  = 1'b0;
        imem_addr = pc;
        if (state == DROP) begin
            imem_req  = 1'b1;
            imem_addr = drop_addr;
        end else begin
            imem_req = pending || !if_valid || !stall;
        end
        if (rst) begin
            imem_req = 1'b0;
        end
    end

    assign outstanding = imem_req && !imem_ack;

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= RUN;
            pc        <= RESET_PC;
            drop_addr <= 32'h0000_0000;
            pending   <= 1'b0;
            if_valid  <= 1'b0;
            if_instr  <= NOP;
            if_pc     <= 32'h0000_0000;
        end else begin
            pending <= outstanding;
            if (redirect) begin
                pc       <= redirect_pc;
                if_valid <= 1'b0;
                if_instr <= NOP;
                if (imem_ack) begin
                    state <= RUN;
                end else if (outstanding) begin
                    // In DROP this rewrites drop_addr with its own value.
                    drop_addr <= imem_addr;
                    state     <= DROP;
                end else begin
                    state <= RUN;
                end
            end else if (state == DROP) begin
                if (imem_ack) begin
                    state <= RUN;
                end
            end else if (imem_ack) begin
                if_instr <= imem_rdata;
                if_pc    <= pc;
                if_valid <= 1'b1;
                pc       <= pc + 32'd4;
            end else if (if_valid && !stall) begin
                if_valid <= 1'b0;
                if_instr <= NOP;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random stall/redirect/
// memory latency, checked against an expected-PC stream scoreboard.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int          total = 0;
    int          bad = 0;
    int          consumed = 0;
    int          wait_states = 0;
    bit          rand_mem = 1'b0;
    int          mem_cnt = 0;

    // Expected program order: sequential PCs from the last reset or redirect.
    logic [31:0] exp_q[$];
    logic [31:0] next_push;

    logic        mon_rst_seen = 1'b0;
    logic        mon_prev_out = 1'b0;
    logic [31:0] mon_prev_addr = 32'h0;
    logic [31:0] mon_exp_pc;

    instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    // One cycle of stimulus: inputs change at negedge, checks follow at +3.
    task automatic cyc(input logic r, input logic st, input logic rd, input logic [31:0] rpc);
        @(negedge CLK);
        rst         = r;
        stall       = st;
        redirect    = rd && !r;
        redirect_pc = rpc;
        if (r) begin
            exp_q.delete();
            next_push = RESET_PC;
        end else if (rd) begin
            exp_q.delete();
            next_push = rpc;
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_push);
            next_push += 32'd4;
        end
        #3;
    endtask

    // Instruction memory: fixed wait states or random latency, word = addr ^ KEY.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge CLK);
            #1;
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            if (rst) begin
                mem_cnt = 0;
            end else if (imem_req) begin
                if (rand_mem) imem_ack = ($urandom_range(0, 2) == 0);
                else          imem_ack = (mem_cnt >= wait_states);
                if (imem_ack) begin
                    mem_cnt    = 0;
                    imem_rdata = mem_word(imem_addr);
                end else begin
                    mem_cnt++;
                end
            end
        end
    end

    // Monitor: protocol rules every cycle, scoreboard pop on each consume.
    initial begin
        forever begin
            @(negedge CLK);
            #3;
            if (rst) check_bit("req_in_reset", imem_req, 1'b0);
            if (mon_rst_seen) begin
                check_bit("reset_valid", if_valid, 1'b0);
                check("reset_instr", if_instr, NOP);
                check("reset_pc", if_pc, 32'h0);
            end
            if (!if_valid) check("nop_when_empty", if_instr, NOP);
            if (mon_prev_out && !rst) begin
                check_bit("req_held", imem_req, 1'b1);
                check("addr_held", imem_addr, mon_prev_addr);
            end
            if (!rst && if_valid && stall) check_bit("no_req_full_stalled", imem_req, 1'b0);
            if (!rst && if_valid && !stall && !redirect) begin
                consumed++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_empty: got pc %08h expected none at t=%0t", if_pc, $time);
                end else begin
                    mon_exp_pc = exp_q.pop_front();
                    check("stream_pc", if_pc, mon_exp_pc);
                    check("stream_instr", if_instr, mem_word(mon_exp_pc));
                end
            end
            mon_rst_seen  = rst;
            mon_prev_out  = imem_req && !imem_ack && !rst;
            mon_prev_addr = imem_addr;
        end
    end

    initial begin
        int  c0;
        logic found;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        next_push   = RESET_PC;

        // Reset, then zero-wait streaming from RESET_PC.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            check_bit("rst_req", imem_req, 1'b0);
            check_bit("rst_valid", if_valid, 1'b0);
            check("rst_instr", if_instr, NOP);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check_bit("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h100);
        check_bit("first_valid", if_valid, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("addr_104", imem_addr, 32'h104);
        check_bit("valid_c2", if_valid, 1'b1);
        check("pc_100", if_pc, 32'h100);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("addr_108", imem_addr, 32'h108);
        check("pc_104", if_pc, 32'h104);

        // Three stalled cycles with 0x108 held in the buffer.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            check("stall_pc", if_pc, 32'h108);
            check_bit("stall_valid", if_valid, 1'b1);
            check_bit("stall_req", imem_req, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("resume_addr", imem_addr, 32'h10C);
        check("resume_pc", if_pc, 32'h108);
        wait_states = 3;

        // Redirect to 0x200 in the second wait cycle of the fetch at 0x110.
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("ws_addr", imem_addr, 32'h110);
        check_bit("ws_noack", imem_ack, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h200);
        check("redir_addr", imem_addr, 32'h110);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("drop_addr1", imem_addr, 32'h110);
        check_bit("drop_req", imem_req, 1'b1);
        check_bit("drop_valid1", if_valid, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("drop_addr2", imem_addr, 32'h110);
        check_bit("drop_ack", imem_ack, 1'b1);
        check_bit("drop_valid2", if_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            check("after_drop_addr", imem_addr, 32'h200);
            check_bit("after_drop_valid", if_valid, 1'b0);
        end
        wait_states = 0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check_bit("redir_valid", if_valid, 1'b1);
        check("redir_pc", if_pc, 32'h200);
        check("redir_instr", if_instr, 32'hA5A5_0200);
        check("addr_204", imem_addr, 32'h204);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("addr_208", imem_addr, 32'h208);

        // Redirect to 0x300 coinciding with an ack.
        cyc(1'b0, 1'b0, 1'b1, 32'h300);
        check_bit("same_cycle_ack", imem_ack, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check_bit("flush_valid", if_valid, 1'b0);
        check("flush_instr", if_instr, NOP);
        check("addr_300", imem_addr, 32'h300);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("pc_300", if_pc, 32'h300);

        // PC wrap past the top of the address space.
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_a0", imem_addr, 32'hFFFF_FFF8);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_a1", imem_addr, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_a2", imem_addr, 32'h0000_0000);
        check("wrap_pc1", if_pc, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_a3", imem_addr, 32'h0000_0004);
        check("wrap_pc2", if_pc, 32'h0000_0000);

        // Random stall, redirect and memory latency.
        rand_mem = 1'b1;
        c0 = consumed;
        for (int i = 0; i < 2000; i++) begin
            cyc(1'b0, ($urandom_range(0, 9) < 3), ($urandom_range(0, 24) == 0),
                $urandom() & 32'hFFFF_FFFC);
        end
        check_bit("random_progress", (consumed - c0) > 100, 1'b1);

        // Reset with a request outstanding and stall high.
        rand_mem    = 1'b0;
        wait_states = 3;
        found       = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            found = imem_req && !imem_ack;
        end
        check_bit("outstanding_found", found, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_bit("pending_under_stall", imem_req, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        check_bit("rst_mid_req", imem_req, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_bit("post_rst_valid", if_valid, 1'b0);
        check("post_rst_instr", if_instr, NOP);
        check("post_rst_pc", if_pc, 32'h0);
        check("post_rst_addr", imem_addr, RESET_PC);
        check_bit("post_rst_req", imem_req, 1'b1);
        wait_states = 0;
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check_bit("final_valid", if_valid, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
